// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Optional two's-complement input, saturating overflow and a count of
// significant digits. Valid/ready handshake on both input and output.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     bin_in valid
//   in_ready     converter can accept a new input (IDLE)
//   bin_in       binary value (unsigned, or two's complement when SIGNED=1)
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts result
//   bcd_out      BCD magnitude, digit 0 in [3:0]; all 9s on overflow
//   neg          result negative (never set for zero)
//   overflow     magnitude exceeded 10^NUM_DIGITS-1
//   digits_used  index of highest nonzero digit + 1, minimum 1
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IN_WIDTH-1:0]               bin_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [4*NUM_DIGITS-1:0]           bcd_out,
    output logic                              neg,
    output logic                              overflow,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digits_used
);

    localparam int unsigned ACC_DIGITS = NUM_DIGITS + 1;
    localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
    localparam int unsigned OUT_W      = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W      = $clog2(IN_WIDTH + 1);
    localparam int unsigned DU_W       = $clog2(NUM_DIGITS + 1);

    // Elaboration-time parameter range check
    generate
        if (IN_WIDTH < 2 || IN_WIDTH > 32) begin : g_bad_in_width
            $error("bin_to_bcd_seq: IN_WIDTH must be in 2..32");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > 10) begin : g_bad_num_digits
            $error("bin_to_bcd_seq: NUM_DIGITS must be in 1..10");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [ACC_W-1:0]      r_bcd;
    logic [IN_WIDTH-1:0]   r_mag;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sign;
    logic                  r_mag_nz;
    logic                  r_lost;
    logic [OUT_W-1:0]      r_bcd_out;
    logic                  r_neg;
    logic                  r_overflow;
    logic [DU_W-1:0]       r_digits_used;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_sign_in;
    logic [IN_WIDTH-1:0]   w_mag_in;
    logic [ACC_W-1:0]      w_adj;
    logic [ACC_W-1:0]      w_bcd_nxt;
    logic                  w_ovf;
    logic [OUT_W-1:0]      w_sat;
    logic [DU_W-1:0]       w_du;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign bcd_out     = r_bcd_out;
    assign neg         = r_neg;
    assign overflow    = r_overflow;
    assign digits_used = r_digits_used;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    // Input magnitude; the most negative value negates to itself, which is
    // exactly its unsigned magnitude.
    assign w_sign_in = (SIGNED != 0) && bin_in[IN_WIDTH-1];
    assign w_mag_in  = w_sign_in ? ((~bin_in) + IN_WIDTH'(1)) : bin_in;

    // Add-3 correction of every digit ahead of the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(ACC_DIGITS); i++) begin
            if (r_bcd[4*i +: 4] > 4'd4) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_nxt = {w_adj[ACC_W-2:0], r_mag[IN_WIDTH-1]};

    // Overflow also tracks bits pushed out of the accumulator top, so very
    // wide inputs into few digits cannot wrap back into range.
    assign w_ovf = r_lost | w_adj[ACC_W-1] | (|w_bcd_nxt[ACC_W-1:OUT_W]);
    assign w_sat = w_ovf ? {NUM_DIGITS{4'h9}} : w_bcd_nxt[OUT_W-1:0];

    // Significant digit count of the value about to be registered
    always_comb begin
        w_du = DU_W'(1);
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_sat[4*i +: 4] != 4'd0) begin
                w_du = DU_W'(i + 1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Shift datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd         <= '0;
            r_mag         <= '0;
            r_cnt         <= '0;
            r_sign        <= 1'b0;
            r_mag_nz      <= 1'b0;
            r_lost        <= 1'b0;
            r_bcd_out     <= '0;
            r_neg         <= 1'b0;
            r_overflow    <= 1'b0;
            r_digits_used <= DU_W'(1);
        end else if (w_accept) begin
            r_bcd    <= '0;
            r_mag    <= w_mag_in;
            r_cnt    <= CNT_W'(IN_WIDTH);
            r_sign   <= w_sign_in;
            r_mag_nz <= |bin_in;
            r_lost   <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_bcd  <= w_bcd_nxt;
            r_mag  <= {r_mag[IN_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt - CNT_W'(1);
            r_lost <= r_lost | w_adj[ACC_W-1];
            if (w_last) begin
                r_bcd_out     <= w_sat;
                r_overflow    <= w_ovf;
                r_neg         <= r_sign & r_mag_nz;
                r_digits_used <= w_du;
            end
        end
    end

endmodule
